sram_port_arbiter: RTL and testbench

- Owns the single read/write port of one 4096x256 single-port SRAM macro with 16-bit write-mask granularity. Shares that port between two requesters.
- Zero-fills the array after reset, then round-robin arbitrates read/write commands.
- Captures the macro's 1-cycle-latency read data into per-port response FIFOs that can be backpressured.
- Sits between the cache refill/writeback logic (port 0), the lookup pipeline (port 1) and the SRAM macro.

---
 rtl/sram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: zero-fills a single-port SRAM after reset, then round-robin shares its port between two requesters
module sram_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 256,
    parameter int MASK_W     = 16,
    parameter int RESP_DEPTH = 2,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*MASK_W-1:0] req_mask,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          resp_valid,
    input  logic [1:0]          resp_ready,
    output logic [2*DATA_W-1:0] resp_rdata,
    output logic                init_done,
    output logic                mem_en,
    output logic                mem_wmode,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [MASK_W-1:0]   mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rr_q, rr_d;
    logic [1:0]        infl_q, infl_d;
    logic              wmode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [MASK_W-1:0] mask_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CW-1:0]     occ_q [2];
    logic [CW-1:0]     occ_d [2];
    logic [PW-1:0]     rptr_q [2];
    logic [PW-1:0]     rptr_d [2];
    logic [PW-1:0]     wptr_q [2];
    logic [PW-1:0]     wptr_d [2];
    logic [DATA_W-1:0] buf_q [2][RESP_DEPTH];
    logic [DATA_W-1:0] buf_d [2][RESP_DEPTH];
    logic              in_init, in_run, gnt_any, gnt;
    logic [1:0]        elig, pop;

    // Arbitrate eligible ports and drive the macro from the init sweep or the granted port
    always_comb begin
        in_init = !reset && state_q == S_INIT;
        in_run  = !reset && state_q == S_RUN;
        for (int p = 0; p < 2; p++)
            elig[p] = in_run && req_valid[p] && (req_write[p] || int'(occ_q[p]) + int'(infl_q[p]) < RESP_DEPTH);
        gnt_any   = |elig;
        gnt       = &elig ? rr_q : elig[1];
        req_ready = gnt_any ? 2'b01 << gnt : 2'b00;
        init_done = in_run;
        mem_en    = in_init || gnt_any;
        mem_wmode = in_init ? 1'b1 : gnt_any ? req_write[gnt] : wmode_q;
        mem_addr  = in_init ? cnt_q : gnt_any ? (gnt ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W]) : addr_q;
        mem_wmask = in_init ? '1 : gnt_any ? (gnt ? req_mask[MASK_W +: MASK_W] : req_mask[0 +: MASK_W]) : mask_q;
        mem_wdata = in_init ? '0 : gnt_any ? (gnt ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W]) : wdata_q;
    end

    // Next state for the init sweep, round-robin pointer, in-flight reads and response FIFOs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (&cnt_q) state_d = S_RUN;
        end
        rr_d   = gnt_any ? !gnt : rr_q;
        infl_d = gnt_any && !req_write[gnt] ? 2'b01 << gnt : 2'b00;
        buf_d  = buf_q;
        for (int p = 0; p < 2; p++) begin
            resp_valid[p] = !reset && occ_q[p] != '0;
            resp_rdata[p*DATA_W +: DATA_W] = buf_q[p][rptr_q[p]];
            pop[p]    = resp_valid[p] && resp_ready[p];
            rptr_d[p] = pop[p] ? (rptr_q[p] == PW'(RESP_DEPTH - 1) ? '0 : rptr_q[p] + PW'(1)) : rptr_q[p];
            wptr_d[p] = infl_q[p] ? (wptr_q[p] == PW'(RESP_DEPTH - 1) ? '0 : wptr_q[p] + PW'(1)) : wptr_q[p];
            occ_d[p]  = occ_q[p] + CW'(infl_q[p]) - CW'(pop[p]);
            if (infl_q[p]) buf_d[p][wptr_q[p]] = mem_rdata;
        end
    end

    // Control state; reset restarts the sweep and drops queued and in-flight reads
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT_EN ? S_INIT : S_RUN;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            infl_q  <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                occ_q[p]  <= '0;
                rptr_q[p] <= '0;
                wptr_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            infl_q  <= infl_d;
            occ_q   <= occ_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
        end
    end

    // Response storage and held macro drive need no reset; occupancy decides validity
    always_ff @(posedge clock) begin
        buf_q   <= buf_d;
        wmode_q <= mem_wmode;
        addr_q  <= mem_addr;
        mask_q  <= mem_wmask;
        wdata_q <= mem_wdata;
    end

    // Eligibility gating must keep every response FIFO from overflowing
    always_ff @(posedge clock) begin
        for (int p = 0; p < 2; p++)
            if (!reset) assert (!(infl_q[p] && !pop[p] && occ_q[p] == CW'(RESP_DEPTH)));
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and randomized checks of sram_port_arbiter against a transaction-level model
module tb_sram_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 256;
    localparam int MW = 16;
    localparam int D  = 2;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, rst1;
    logic [1:0]      req_valid, req_write, resp_ready;
    logic [2*AW-1:0] req_addr;
    logic [2*MW-1:0] req_mask;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready, resp_valid;
    logic [2*DW-1:0] resp_rdata;
    logic            init_done, mem_en, mem_wmode;
    logic [AW-1:0]   mem_addr;
    logic [MW-1:0]   mem_wmask;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic [1:0]      u1_req_ready, u1_resp_valid;
    logic [2*DW-1:0] u1_resp_rdata;
    logic            u1_init_done, u1_mem_en, u1_mem_wmode;
    logic [AW-1:0]   u1_mem_addr;
    logic [MW-1:0]   u1_mem_wmask;
    logic [DW-1:0]   u1_mem_wdata;
    logic [DW-1:0]   u1_mem_rdata = '0;

    sram_port_arbiter dut (
        .clock(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done), .mem_en(mem_en), .mem_wmode(mem_wmode),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    sram_port_arbiter #(.INIT_EN(1'b0)) u1 (
        .clock(clk), .reset(rst1),
        .req_valid(req_valid), .req_ready(u1_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
        .resp_valid(u1_resp_valid), .resp_ready(resp_ready), .resp_rdata(u1_resp_rdata),
        .init_done(u1_init_done), .mem_en(u1_mem_en), .mem_wmode(u1_mem_wmode),
        .mem_addr(u1_mem_addr), .mem_wmask(u1_mem_wmask), .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata)
    );

    int            checks, failures, cyc;
    logic          rr;
    int            gcnt [2];
    ent_t          qs [2][$];
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] sram [1 << AW];
    logic          seeded = 1'b0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [MW-1:0] m);
        for (int l = 0; l < MW; l++)
            if (m[l]) old[l*16 +: 16] = nw[l*16 +: 16];
        return old;
    endfunction

    function automatic logic [DW-1:0] rnd256();
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // SRAM macro: garbage contents at power-up, masked writes, one-cycle read latency
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= rnd256();
            mem_rdata <= rnd256();
            seeded    <= 1'b1;
        end else if (mem_en) begin
            if (mem_wmode) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wmask);
            else mem_rdata <= sram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_req_ready", DW'(req_ready), DW'(0));
        check("rst_resp_valid", DW'(resp_valid), DW'(0));
        check("rst_init_done", DW'(init_done), DW'(0));
        check("rst_mem_en", DW'(mem_en), DW'(0));
    endtask

    // Full sweep: every address written with zeros under a full mask, no command accepted
    task automatic run_init();
        int bad = 0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        qs[0].delete();
        qs[1].delete();
        rr  = 1'b0;
        cyc = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            req_valid = 2'($urandom);
            req_write = 2'($urandom);
            #1;
            if (i == 0) check("init_first_addr", DW'(mem_addr), DW'(0));
            if (!(mem_en === 1'b1 && mem_wmode === 1'b1 && mem_addr === AW'(i) && mem_wmask === '1 &&
                  mem_wdata === '0 && req_ready === 2'b00 && init_done === 1'b0)) bad++;
            @(negedge clk);
        end
        check("init_seq_bad_cycles", DW'(bad), DW'(0));
        req_valid = 2'b00;
    endtask

    // One RUN cycle: compare outputs with the transaction model, then advance the model
    task automatic step();
        logic [1:0] elig;
        logic       any, g, v;
        int         gi;
        ent_t       e;
        #1;
        for (int p = 0; p < 2; p++) elig[p] = req_valid[p] && (req_write[p] || qs[p].size() < D);
        any = |elig;
        g   = &elig ? rr : elig[1];
        gi  = int'(g);
        check("init_done", DW'(init_done), DW'(1));
        check("req_ready", DW'(req_ready), any ? DW'(1) << gi : DW'(0));
        check("mem_en", DW'(mem_en), DW'(any));
        if (any) begin
            check("mem_wmode", DW'(mem_wmode), DW'(req_write[gi]));
            check("mem_addr", DW'(mem_addr), DW'(req_addr[gi*AW +: AW]));
            if (req_write[gi]) begin
                check("mem_wmask", DW'(mem_wmask), DW'(req_mask[gi*MW +: MW]));
                check("mem_wdata", mem_wdata, req_wdata[gi*DW +: DW]);
            end
        end
        for (int p = 0; p < 2; p++) begin
            v = qs[p].size() > 0 && qs[p][0].c + 2 <= cyc;
            check($sformatf("resp_valid%0d", p), DW'(resp_valid[p]), DW'(v));
            if (v) begin
                check($sformatf("resp_rdata%0d", p), resp_rdata[p*DW +: DW], qs[p][0].d);
                if (resp_ready[p]) void'(qs[p].pop_front());
            end
        end
        if (any) begin
            gcnt[gi]++;
            if (req_write[gi]) begin
                ref_mem[req_addr[gi*AW +: AW]] = merge(ref_mem[req_addr[gi*AW +: AW]], req_wdata[gi*DW +: DW], req_mask[gi*MW +: MW]);
            end else begin
                e.d = ref_mem[req_addr[gi*AW +: AW]];
                e.c = cyc;
                qs[gi].push_back(e);
            end
            rr = !g;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
        req_write[p]          = wr;
        req_addr[p*AW +: AW]  = a;
        req_mask[p*MW +: MW]  = m;
        req_wdata[p*DW +: DW] = d;
    endtask

    initial begin
        int g0, g1;
        checks     = 0;
        failures   = 0;
        gcnt[0]    = 0;
        gcnt[1]    = 0;
        reset      = 1'b1;
        rst1       = 1'b1;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        req_addr   = '0;
        req_mask   = '0;
        req_wdata  = '0;
        resp_ready = 2'b00;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset();
        end
        check("u1_rst_init_done", DW'(u1_init_done), DW'(0));
        rst1      = 1'b0;
        req_valid = 2'b01;
        set_port(0, 1'b0, 12'h123, '0, '0);
        #1;
        check("u1_init_done", DW'(u1_init_done), DW'(1));
        check("u1_req_ready", DW'(u1_req_ready), DW'(2'b01));
        check("u1_mem_en", DW'(u1_mem_en), DW'(1));
        check("u1_mem_addr", DW'(u1_mem_addr), DW'(12'h123));
        @(negedge clk);
        rst1      = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        run_init();

        resp_ready = 2'b11;
        req_valid  = 2'b01;
        set_port(0, 1'b0, 12'h7FF, '0, '0);
        step();
        req_valid = 2'b00;
        repeat (3) step();

        req_valid = 2'b01;
        set_port(0, 1'b1, 12'h010, 16'h0001, {rnd256()} & ~DW'(16'hFFFF) | DW'(16'hBEEF));
        step();
        req_valid = 2'b10;
        set_port(1, 1'b0, 12'h010, '0, '0);
        step();
        req_valid = 2'b00;
        step();
        #1;
        check("raw_valid", DW'(resp_valid[1]), DW'(1));
        check("raw_beef", resp_rdata[DW +: DW], DW'(16'hBEEF));
        step();
        repeat (2) step();

        g0 = gcnt[0];
        g1 = gcnt[1];
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1'b0, AW'($urandom_range(0, 31)), '0, '0);
            set_port(1, 1'b0, AW'($urandom_range(0, 31)), '0, '0);
            step();
        end
        check("alt_grants0", DW'(gcnt[0] - g0), DW'(4));
        check("alt_grants1", DW'(gcnt[1] - g1), DW'(4));
        req_valid = 2'b00;
        repeat (3) step();

        g1 = gcnt[1];
        resp_ready = 2'b01;
        req_valid  = 2'b11;
        for (int i = 0; i < 10; i++) begin
            set_port(0, 1'b1, AW'($urandom_range(0, 31)), 16'($urandom), rnd256());
            set_port(1, 1'b0, AW'($urandom_range(0, 31)), '0, '0);
            step();
        end
        check("bp_grants1", DW'(gcnt[1] - g1), DW'(D));
        #1;
        check("bp_ready1", DW'(req_ready[1]), DW'(0));
        resp_ready = 2'b11;
        for (int i = 0; i < 6; i++) step();
        check("bp_resume", DW'(gcnt[1] - g1 > D), DW'(1));
        req_valid = 2'b00;
        repeat (4) step();

        resp_ready = 2'b00;
        req_valid  = 2'b10;
        set_port(1, 1'b0, 12'h010, '0, '0);
        step();
        step();
        reset = 1'b1;
        #1;
        check_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 2'b00;
        run_init();
        resp_ready = 2'b11;
        repeat (4) step();

        for (int i = 0; i < 1500; i++) begin
            req_valid  = 2'($urandom);
            resp_ready = {($urandom % 4) != 0, ($urandom % 4) != 0};
            for (int p = 0; p < 2; p++)
                set_port(p, 1'($urandom), AW'($urandom_range(0, 15)), 16'($urandom), rnd256());
            step();
        end
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
